// File: rtl/nand_burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// nand_burst_sequencer_if
//   Bundles every non-clock, non-reset signal of the NAND word-burst engine.
//
//   Command side : start, dir, length, base_addr, abort  -> engine
//                  busy, done, error, count (+checksum)  <- engine
//   IO unit side : io_activate, io_type, io_wdata        <- engine
//                  io_rdata, io_busy                     -> engine
//   Page buffer  : buf_addr, buf_rd, buf_we, buf_wdata   <- engine
//                  buf_rdata (valid the cycle after buf_rd) -> engine
//
//   modport master : the burst engine itself
//   modport slave  : its surroundings (command sequencer, IO unit, buffer)
//
//   Optional macro BURST_CHECKSUM_EN adds the 16-bit checksum signal.
// ---------------------------------------------------------------------------
interface nand_burst_sequencer_if #(
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 13
);
    logic              start;
    logic              dir;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] base_addr;
    logic              abort;
    logic              busy;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  count;
`ifdef BURST_CHECKSUM_EN
    logic [15:0]       checksum;
`endif
    logic              io_activate;
    logic              io_type;
    logic [15:0]       io_wdata;
    logic [15:0]       io_rdata;
    logic              io_busy;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_rd;
    logic [15:0]       buf_rdata;
    logic              buf_we;
    logic [15:0]       buf_wdata;

    modport master (
`ifdef BURST_CHECKSUM_EN
        output checksum,
`endif
        input  start, dir, length, base_addr, abort,
        output busy, done, error, count,
        output io_activate, io_type, io_wdata,
        input  io_rdata, io_busy,
        output buf_addr, buf_rd, buf_we, buf_wdata,
        input  buf_rdata
    );

    modport slave (
`ifdef BURST_CHECKSUM_EN
        input  checksum,
`endif
        output start, dir, length, base_addr, abort,
        input  busy, done, error, count,
        input  io_activate, io_type, io_wdata,
        output io_rdata, io_busy,
        input  buf_addr, buf_rd, buf_we, buf_wdata,
        output buf_rdata
    );
endinterface

// File: rtl/nand_burst_sequencer.sv
// ---------------------------------------------------------------------------
// nand_burst_sequencer
//   Moves a burst of `length` 16-bit words between the controller page
//   buffer and the NAND data IO unit. One io_activate pulse per word; the IO
//   unit's busy rise/fall handshake delimits each word. Read bursts
//   (dir=1) store io_rdata into the buffer, write bursts (dir=0) fetch a
//   buffer word into io_wdata before activating the IO unit.
//
//   Ports
//     clk    : clock, all logic on the rising edge
//     nreset : asynchronous active-low reset
//     bus    : nand_burst_sequencer_if.master (command, IO unit, buffer)
//
//   Parameters
//     ADDR_W     : buffer word address width (addresses wrap mod 2^ADDR_W)
//     LEN_W      : width of length / count
//     HI_TIMEOUT : WAIT_HI cycles allowed for io_busy to rise
//
//   Optional macro BURST_CHECKSUM_EN: adds a 16-bit running sum of the words
//   transferred (read: io_rdata, write: io_wdata), cleared on start.
//
//   All outputs are registered: each is loaded on the edge that enters the
//   state in which it is meant to be seen, so it lines up with that state.
// ---------------------------------------------------------------------------
module nand_burst_sequencer #(
    parameter int ADDR_W     = 13,
    parameter int LEN_W      = 13,
    parameter int HI_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     nreset,
    nand_burst_sequencer_if.master   bus
);

    localparam logic IO_WRITE = 1'b0;
    localparam logic IO_READ  = 1'b1;

    localparam int TMR_W = (HI_TIMEOUT > 2) ? $clog2(HI_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HI_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_STORE,
        S_FIN
    } state_t;

    state_t            state_reg;
    logic              dir_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  count_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              abort_reg;
    logic [TMR_W-1:0]  timer_reg;

    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic              io_activate_reg;
    logic              io_type_reg;
    logic [15:0]       io_wdata_reg;
    logic [ADDR_W-1:0] buf_addr_reg;
    logic              buf_rd_reg;
    logic              buf_we_reg;
    logic [15:0]       buf_wdata_reg;
`ifdef BURST_CHECKSUM_EN
    logic [15:0]       checksum_reg;
`endif

    logic [LEN_W-1:0]  count_next;
    logic [ADDR_W-1:0] addr_next;
    logic              finish_now;

    assign count_next = count_reg + LEN_W'(1);
    assign addr_next  = addr_reg + ADDR_W'(1);
    // An abort arriving in the STORE cycle itself is honoured as well.
    assign finish_now = (count_next == len_reg) || abort_reg || bus.abort;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg       <= S_IDLE;
            dir_reg         <= 1'b0;
            len_reg         <= '0;
            count_reg       <= '0;
            addr_reg        <= '0;
            abort_reg       <= 1'b0;
            timer_reg       <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            io_activate_reg <= 1'b0;
            io_type_reg     <= IO_WRITE;
            io_wdata_reg    <= '0;
            buf_addr_reg    <= '0;
            buf_rd_reg      <= 1'b0;
            buf_we_reg      <= 1'b0;
            buf_wdata_reg   <= '0;
`ifdef BURST_CHECKSUM_EN
            checksum_reg    <= '0;
`endif
        end else begin
            // Single-cycle strobes default low; only the entering edge sets them.
            done_reg        <= 1'b0;
            io_activate_reg <= 1'b0;
            buf_rd_reg      <= 1'b0;
            buf_we_reg      <= 1'b0;

            // Sticky abort request, collected in every busy state.
            if (state_reg != S_IDLE && bus.abort) begin
                abort_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        dir_reg     <= bus.dir;
                        len_reg     <= bus.length;
                        addr_reg    <= bus.base_addr;
                        count_reg   <= '0;
                        error_reg   <= 1'b0;
                        abort_reg   <= 1'b0;
                        io_type_reg <= bus.dir ? IO_READ : IO_WRITE;
                        busy_reg    <= 1'b1;
`ifdef BURST_CHECKSUM_EN
                        checksum_reg <= '0;
`endif
                        if (bus.length == '0) begin
                            state_reg <= S_FIN;
                            done_reg  <= 1'b1;
                        end else if (!bus.dir) begin
                            state_reg    <= S_FETCH;
                            buf_rd_reg   <= 1'b1;
                            buf_addr_reg <= bus.base_addr;
                        end else begin
                            state_reg       <= S_ISSUE;
                            io_activate_reg <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    state_reg <= S_LOAD;
                end

                S_LOAD: begin
                    // buf_rdata answers the FETCH read now; held until the next LOAD.
                    io_wdata_reg    <= bus.buf_rdata;
                    state_reg       <= S_ISSUE;
                    io_activate_reg <= 1'b1;
                end

                S_ISSUE: begin
                    state_reg <= S_WAIT_HI;
                    timer_reg <= '0;
                end

                S_WAIT_HI: begin
                    if (bus.io_busy) begin
                        state_reg <= S_WAIT_LO;
                    end else if (timer_reg == TMR_LAST) begin
                        error_reg <= 1'b1;
                        state_reg <= S_FIN;
                        done_reg  <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end

                S_WAIT_LO: begin
                    if (!bus.io_busy) begin
                        state_reg     <= S_STORE;
                        // Captured for every word: it is the buffer write data
                        // on reads and the checksum operand on reads.
                        buf_wdata_reg <= bus.io_rdata;
                        if (dir_reg) begin
                            buf_we_reg   <= 1'b1;
                            buf_addr_reg <= addr_reg;
                        end
                    end
                end

                S_STORE: begin
                    count_reg <= count_next;
                    addr_reg  <= addr_next;
`ifdef BURST_CHECKSUM_EN
                    checksum_reg <= checksum_reg + (dir_reg ? buf_wdata_reg : io_wdata_reg);
`endif
                    if (finish_now) begin
                        state_reg <= S_FIN;
                        done_reg  <= 1'b1;
                    end else if (dir_reg) begin
                        state_reg       <= S_ISSUE;
                        io_activate_reg <= 1'b1;
                    end else begin
                        state_reg    <= S_FETCH;
                        buf_rd_reg   <= 1'b1;
                        buf_addr_reg <= addr_next;
                    end
                end

                S_FIN: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.error       = error_reg;
    assign bus.count       = count_reg;
    assign bus.io_activate = io_activate_reg;
    assign bus.io_type     = io_type_reg;
    assign bus.io_wdata    = io_wdata_reg;
    assign bus.buf_addr    = buf_addr_reg;
    assign bus.buf_rd      = buf_rd_reg;
    assign bus.buf_we      = buf_we_reg;
    assign bus.buf_wdata   = buf_wdata_reg;
`ifdef BURST_CHECKSUM_EN
    assign bus.checksum    = checksum_reg;
`endif

endmodule

// File: tb/tb_nand_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nand_burst_sequencer
//   Bench for nand_burst_sequencer. Behavioural page buffer (registered
//   read) and IO unit (busy for a programmable number of cycles after each
//   activate, data_out updated as busy falls) surround the engine. Expected
//   buffer writes, IO data, counts, latencies and checksums are worked out
//   from the burst parameters with plain arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nand_burst_sequencer;

    localparam int ADDR_W = 13;
    localparam int LEN_W  = 13;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    nand_burst_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    nand_burst_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .HI_TIMEOUT(8)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Environment state: mem/rd_words written only by the initial block.
    logic [15:0] mem [0:8191];
    logic [15:0] rd_words [0:1023];
    int          io_busy_len = 5;
    bit          io_never    = 1'b0;

    // Event logs written only by the monitors.
    int          act_cnt        = 0;
    int          act_while_busy = 0;
    int          done_cnt       = 0;
    int          rd_idx         = 0;
    int          io_left        = 0;
    logic [15:0] io_log [$];
    logic [12:0] wr_addr_log [$];
    logic [15:0] wr_data_log [$];

    // Page buffer model
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bus.buf_rdata <= '0;
        end else begin
            if (bus.buf_rd) bus.buf_rdata <= mem[bus.buf_addr];
            if (bus.buf_we) begin
                wr_addr_log.push_back(bus.buf_addr);
                wr_data_log.push_back(bus.buf_wdata);
            end
            if (bus.done) done_cnt = done_cnt + 1;
        end
    end

    // IO unit model
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bus.io_busy  <= 1'b0;
            bus.io_rdata <= '0;
            io_left = 0;
        end else if (bus.io_activate) begin
            act_cnt = act_cnt + 1;
            io_log.push_back(bus.io_wdata);
            if (bus.io_busy) act_while_busy = act_while_busy + 1;
            if (!io_never) begin
                bus.io_busy <= 1'b1;
                io_left = io_busy_len - 1;
            end
        end else if (bus.io_busy) begin
            if (io_left == 0) begin
                bus.io_busy  <= 1'b0;
                bus.io_rdata <= rd_words[rd_idx & 1023];
                rd_idx = rd_idx + 1;
            end else begin
                io_left = io_left - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one start pulse; returns at the first negedge after acceptance.
    task automatic launch(input bit d, input int len, input logic [12:0] base);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dir       = d;
        bus.length    = LEN_W'(len);
        bus.base_addr = base;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Called right after launch; cyc=1 is the first cycle after acceptance.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/done_seen"}, 32'(bus.done), 32'd1);
    endtask

    // Compare a finished burst (called at the negedge where done is high).
    task automatic check_burst(input string tag, input bit d, input int words, input int exp_act,
                               input logic [12:0] base, input bit exp_err,
                               input int a0, input int w0, input int i0, input int r0, input int d0);
        logic [15:0] sum;
        logic [12:0] a;
        sum = '0;
        check({tag, "/count"}, 32'(bus.count), 32'(words));
        check({tag, "/error"}, 32'(bus.error), 32'(exp_err));
        @(negedge clk);
        check({tag, "/busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "/done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "/activates"}, 32'(act_cnt - a0), 32'(exp_act));
        check({tag, "/act_while_busy"}, 32'(act_while_busy), 32'd0);
        if (d) begin
            check({tag, "/buf_writes"}, 32'(wr_addr_log.size() - w0), 32'(words));
            for (int i = 0; i < words && (w0 + i) < wr_addr_log.size(); i++) begin
                a = base + 13'(i);
                check({tag, $sformatf("/waddr%0d", i)}, 32'(wr_addr_log[w0 + i]), 32'(a));
                check({tag, $sformatf("/wdata%0d", i)}, 32'(wr_data_log[w0 + i]),
                      32'(rd_words[(r0 + i) & 1023]));
                sum = sum + rd_words[(r0 + i) & 1023];
            end
        end else begin
            check({tag, "/buf_writes"}, 32'(wr_addr_log.size() - w0), 32'd0);
            for (int i = 0; i < exp_act && (i0 + i) < io_log.size(); i++) begin
                a = base + 13'(i);
                check({tag, $sformatf("/io%0d", i)}, 32'(io_log[i0 + i]), 32'(mem[a]));
                if (i < words) sum = sum + mem[a];
            end
        end
`ifdef BURST_CHECKSUM_EN
        check({tag, "/checksum"}, 32'(bus.checksum), 32'(sum));
`endif
        $display("burst %s dir=%0d words=%0d base=%0h err=%0d", tag, d, words, base, exp_err);
    endtask

    int a0, w0, i0, r0, d0, cyc, len, lbusy;
    bit d;
    logic [12:0] base;

    task automatic snap(output int sa, output int sw, output int si, output int sr, output int sd);
        sa = act_cnt; sw = wr_addr_log.size(); si = io_log.size(); sr = rd_idx; sd = done_cnt;
    endtask

    initial begin
        bus.start = 1'b0; bus.dir = 1'b0; bus.length = '0; bus.base_addr = '0; bus.abort = 1'b0;
        nreset = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 1024; i++) rd_words[i] = 16'($urandom);
        #13;
        // Reset state
        check("rst/busy", 32'(bus.busy), 0);
        check("rst/done", 32'(bus.done), 0);
        check("rst/error", 32'(bus.error), 0);
        check("rst/count", 32'(bus.count), 0);
        check("rst/io_activate", 32'(bus.io_activate), 0);
        check("rst/io_type", 32'(bus.io_type), 0);
        check("rst/io_wdata", 32'(bus.io_wdata), 0);
        check("rst/buf_rd_we", {30'd0, bus.buf_rd, bus.buf_we}, 0);
        check("rst/buf_addr", 32'(bus.buf_addr), 0);
        @(negedge clk); nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed read: 4 words at 0x010, IO busy 5 cycles -> 3+5 cycles per word
        io_busy_len = 5;
        snap(a0, w0, i0, r0, d0);
        for (int i = 0; i < 4; i++) rd_words[(r0 + i) & 1023] = 16'hA001 + 16'(i);
        launch(1'b1, 4, 13'h010);
        check("rd4/io_type", 32'(bus.io_type), 1);
        wait_done("rd4", cyc);
        check("rd4/latency", 32'(cyc), 32'(4 * 8 + 1));
        check_burst("rd4", 1'b1, 4, 4, 13'h010, 1'b0, a0, w0, i0, r0, d0);

        // Directed write across the top of the buffer (address wrap)
        mem[13'h1FFE] = 16'h1111; mem[13'h1FFF] = 16'h2222; mem[0] = 16'h3333;
        io_busy_len = 2;
        snap(a0, w0, i0, r0, d0);
        launch(1'b0, 3, 13'h1FFE);
        check("wr3/io_type", 32'(bus.io_type), 0);
        wait_done("wr3", cyc);
        check("wr3/latency", 32'(cyc), 32'(3 * (5 + 2) + 1));
        check_burst("wr3", 1'b0, 3, 3, 13'h1FFE, 1'b0, a0, w0, i0, r0, d0);

        // Zero-length burst: done in the cycle after acceptance, no activate
        snap(a0, w0, i0, r0, d0);
        launch(1'b1, 0, 13'h0123);
        wait_done("len0", cyc);
        check("len0/latency", 32'(cyc), 1);
        check_burst("len0", 1'b1, 0, 0, 13'h0123, 1'b0, a0, w0, i0, r0, d0);

        // Abort during the 3rd word's WAIT_LO of an 8-word read
        io_busy_len = 5;
        snap(a0, w0, i0, r0, d0);
        launch(1'b1, 8, 13'h0400);
        for (int k = 0; k < 200 && (act_cnt - a0) < 3; k++) @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done("abort", cyc);
        check_burst("abort", 1'b1, 3, 3, 13'h0400, 1'b0, a0, w0, i0, r0, d0);

        // IO unit never raises busy: 8 WAIT_HI cycles then error + done
        io_never = 1'b1;
        snap(a0, w0, i0, r0, d0);
        launch(1'b1, 2, 13'h0050);
        wait_done("tmo", cyc);
        check("tmo/latency", 32'(cyc), 32'(1 + 8 + 1));
        check_burst("tmo", 1'b1, 0, 1, 13'h0050, 1'b1, a0, w0, i0, r0, d0);
        io_never = 1'b0;
        check("tmo/error_sticky", 32'(bus.error), 1);
        snap(a0, w0, i0, r0, d0);
        launch(1'b1, 1, 13'h0060);
        check("tmo/error_cleared", 32'(bus.error), 0);
        wait_done("after_tmo", cyc);
        check_burst("after_tmo", 1'b1, 1, 1, 13'h0060, 1'b0, a0, w0, i0, r0, d0);

`ifdef BURST_CHECKSUM_EN
        // Checksum wraps mod 2^16
        io_busy_len = 1;
        snap(a0, w0, i0, r0, d0);
        rd_words[r0 & 1023] = 16'hFFFF; rd_words[(r0 + 1) & 1023] = 16'h0002;
        launch(1'b1, 2, 13'h0200);
        wait_done("csum", cyc);
        check("csum/value", 32'(bus.checksum), 32'h0001);
        check_burst("csum", 1'b1, 2, 2, 13'h0200, 1'b0, a0, w0, i0, r0, d0);
`endif

        // Randomised bursts
        for (int t = 0; t < 12; t++) begin
            d     = 1'($urandom_range(0, 1));
            len   = int'($urandom_range(1, 6));
            lbusy = int'($urandom_range(1, 6));
            base  = 13'($urandom_range(0, 8191));
            io_busy_len = lbusy;
            snap(a0, w0, i0, r0, d0);
            launch(d, len, base);
            wait_done($sformatf("rnd%0d", t), cyc);
            check($sformatf("rnd%0d/latency", t), 32'(cyc),
                  32'(len * ((d ? 3 : 5) + lbusy) + 1));
            check_burst($sformatf("rnd%0d", t), d, len, len, base, 1'b0, a0, w0, i0, r0, d0);
        end

        // Asynchronous reset during the 2nd word of a 5-word write
        io_busy_len = 3;
        snap(a0, w0, i0, r0, d0);
        launch(1'b0, 5, 13'h0700);
        for (int k = 0; k < 200 && (act_cnt - a0) < 2; k++) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("arst/busy", 32'(bus.busy), 0);
        check("arst/count", 32'(bus.count), 0);
        check("arst/io_wdata", 32'(bus.io_wdata), 0);
        check("arst/strobes", {28'd0, bus.io_activate, bus.buf_rd, bus.buf_we, bus.done}, 0);
        @(negedge clk); nreset = 1'b1;
        repeat (30) @(negedge clk);
        check("arst/no_done", 32'(done_cnt - d0), 0);
        check("arst/no_more_act", 32'(act_cnt - a0), 2);
        check("arst/idle", 32'(bus.busy), 0);
        $display("burst arst write reset after %0d activates", act_cnt - a0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
